param_microprocessor_core: RTL and testbench
============================================

// Module: param_microprocessor_core
// PURPOSE
//  Parametrised successor to the team's 8-bit 4-register load/store core.
//  Same 4-op ISA (ADD, LOAD, STORE, JUMP); data width, register count, data-memory depth and PC width are parameters.
//  Adds a valid/ready fetch handshake with stall, registered write-back trace outputs and a sticky signed-overflow flag.
//  Sits between the instruction ROM/switch front end and the 7-segment display logic; clock divider stays outside.
// PARAMETERS
//  DATA_W  8  register/memory word width (>=4)
//  RA_W    2  register-address bits; NUM_REGS = 2**RA_W
//  MEM_AW  5  data-memory address bits; depth = 2**MEM_AW
//  PC_W    8  program-counter width
//  INSTR_W (derived, localparam) = 2 + 3*RA_W
// PORTS
//  clock        in   1        core clock, all state on rising edge
//  reset        in   1        synchronous, active-high
//  instruction  in   INSTR_W  instruction word at instruction_address
//  instr_valid  in   1        instruction word is valid this cycle
//  instr_ready  out  1        core accepts instruction (= ~halted)
//  instruction_address out PC_W  current PC
//  op           out  2        opcode of last executed instruction
//  mem_read     out  1        1-cycle strobe: LOAD executed
//  mem_write    out  1        1-cycle strobe: STORE executed
//  reg_write    out  1        1-cycle strobe: ADD or LOAD executed
//  wb_reg       out  RA_W     destination register of last write
//  wb_data      out  DATA_W   value written by last write
//  ovf          out  1        sticky signed overflow from ADD
//  halted       out  1        core halted (CPU_HALT_EN only; else tied 0)
// BEHAVIOUR
//  Fields: op=instr[INSTR_W-1 -:2]; rs=next RA_W bits; rt=next RA_W bits; lo=instr[RA_W-1:0].
//  imm = sign-extend(lo) to DATA_W; joff = sign-extend(instr[INSTR_W-3:0]) to PC_W.
//  Execute happens on a rising edge with instr_valid & instr_ready; single-cycle, all outputs registered.
//  Operands read pre-edge values; back-to-back dependent instructions need no forwarding.
//  00 ADD:   R[lo] <= R[rs]+R[rt] mod 2**DATA_W; reg_write=1, wb_reg=lo; ovf |= signed overflow.
//  01 LOAD:  R[rt] <= M[(R[rs]+imm) mod 2**MEM_AW]; mem_read=1, reg_write=1, wb_reg=rt.
//  10 STORE: M[(R[rs]+imm) mod 2**MEM_AW] <= R[rt]; mem_write=1; wb_* hold.
//  11 JUMP:  PC <= PC+1+joff mod 2**PC_W; no strobes.
//  Non-jump: PC <= PC+1, wraps 2**PC_W-1 -> 0.
//  Address arithmetic is DATA_W-bit then truncated to MEM_AW bits (wrap, never out of range).
//  Stall (instr_valid=0): PC, registers, memory, op, wb_*, ovf hold; all strobes 0.
//  Strobes are high exactly one cycle after each executed instruction of matching type.
//  Reset (any cycle, overrides execute): PC=0, R[*]=0, op=0, strobes=0, wb_reg=0, wb_data=0,
//   ovf=0, halted=0; M[i]=i for i<depth/2, M[i]=-(i-depth/2) for i>=depth/2.
// CONFIGURATION
//  CPU_HALT_EN defined: JUMP with joff=-1 (self-loop) executes, PC unchanged, then halted=1,
//   instr_ready=0; core frozen until reset.
//  CPU_HALT_EN undefined: self-loop is an ordinary JUMP each cycle; halted tied 0, instr_ready=1.
// TESTING (defaults, INSTR_W=8)
//  reset, instr 0x45 (LOAD r1<=M[r0+1]) valid -> reg_write=1, mem_read=1, wb_reg=1, wb_data=0x01, PC=1
//  then 0x16 (ADD r2=r1+r1) -> wb_reg=2, wb_data=0x02, mem_read=0, PC=2; hold valid=0 3 cycles -> PC=2, strobes 0
//  0x8B (STORE r2->M[r0-1]=M[31]) -> mem_write=1; then 0x4F (LOAD r3<=M[31]) -> wb_data=0x02
//  at PC=4, 0xC2 (JUMP +2) -> PC=7; ADD r1=r1+r1 seven times from r1=1 -> r1=0x80 at 7th, ovf=1 and stays 1
//  0xFF at PC=9 -> PC=9; with CPU_HALT_EN halted=1, instr_ready=0 next cycle; without, PC stays 9, ready=1
//  reset asserted during STORE strobe cycle -> next cycle strobes 0, PC=0, ovf=0, LOAD M[17] returns 0xFF

Source files
------------

// File: rtl/param_microprocessor_core.sv
// param_microprocessor_core
//   Parameterised single-cycle load/store core with a four-op ISA
//   (ADD, LOAD, STORE, JUMP). Data width, register count, data-memory depth
//   and PC width are parameters. All outputs are registered; the write-back
//   trace (op, strobes, wb_reg, wb_data) describes the instruction that
//   executed on the previous rising edge.
//
//   Optional build macro: CPU_HALT_EN
//     defined   - a JUMP to itself (joff = -1) executes once, then the core
//                 enters the halted state and refuses further instructions
//                 until reset.
//     undefined - the self-loop is an ordinary JUMP; halted is tied low and
//                 instr_ready is tied high.
//
//   Fetch handshake: an instruction executes on a rising edge where
//   instr_valid and instr_ready are both high. instr_ready depends only on
//   core state (never on instr_valid), and a word offered while instr_ready
//   is low is simply ignored; the source keeps presenting the word addressed
//   by instruction_address. With instr_valid low the core stalls: PC,
//   registers, memory, op, wb_* and ovf hold and every strobe is 0.
//
//   Parameter assumptions: DATA_W > RA_W, DATA_W >= MEM_AW, PC_W > 3*RA_W.
module param_microprocessor_core #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 2,
    parameter int MEM_AW = 5,
    parameter int PC_W   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2+3*RA_W-1:0]   instruction,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [PC_W-1:0]       instruction_address,
    output logic [1:0]            op,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [RA_W-1:0]       wb_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  ovf,
    output logic                  halted
);

    localparam int INSTR_W   = 2 + 3 * RA_W;
    localparam int NUM_REGS  = 2 ** RA_W;
    localparam int MEM_DEPTH = 2 ** MEM_AW;
    localparam int JOFF_W    = 3 * RA_W;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] mem  [MEM_DEPTH];
    logic [PC_W-1:0]   pc;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [1:0]        f_op;
    logic [RA_W-1:0]   f_rs;
    logic [RA_W-1:0]   f_rt;
    logic [RA_W-1:0]   f_lo;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   joff;

    assign f_op = instruction[INSTR_W-1 -: 2];
    assign f_rs = instruction[INSTR_W-3 -: RA_W];
    assign f_rt = instruction[INSTR_W-3-RA_W -: RA_W];
    assign f_lo = instruction[RA_W-1:0];

    // LOAD/STORE displacement is the low register field, sign-extended.
    assign imm  = {{(DATA_W-RA_W){f_lo[RA_W-1]}}, f_lo};

    // JUMP offset spans everything below the opcode, sign-extended to PC_W.
    assign joff = {{(PC_W-JOFF_W){instruction[JOFF_W-1]}}, instruction[JOFF_W-1:0]};

    // ------------------------------------------------------------------
    // Datapath (operands are the pre-edge register values, so a dependent
    // instruction on the next cycle sees the freshly written value without
    // any forwarding)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] sum;
    logic              add_ovf;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] load_data;
    logic [PC_W-1:0]   pc_seq;
    logic [PC_W-1:0]   pc_jump;
    logic              fire;

    assign op_a      = regs[f_rs];
    assign op_b      = regs[f_rt];
    assign sum       = op_a + op_b;

    // Signed overflow: both addends share a sign the result does not.
    assign add_ovf   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                       (sum[DATA_W-1]  != op_a[DATA_W-1]);

    // Effective address is formed at full data width, then wrapped into
    // the memory; it can never point outside the array.
    assign mem_addr  = MEM_AW'(op_a + imm);
    assign load_data = mem[mem_addr];

    assign pc_seq    = pc + PC_ONE;
    assign pc_jump   = pc_seq + joff;

    assign fire      = instr_valid & instr_ready;

    assign instruction_address = pc;

    // ------------------------------------------------------------------
    // Optional halt on self-loop
    // ------------------------------------------------------------------
`ifdef CPU_HALT_EN
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    logic run_state;
    logic self_loop;

    // A JUMP whose offset is all ones lands back on itself.
    assign self_loop = (f_op == OP_JUMP) && (instruction[JOFF_W-1:0] == '1);

    // Run/halt state: the self-loop executes once, then the core freezes.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_state <= ST_RUN;
        end else if (fire && self_loop) begin
            run_state <= ST_HALT;
        end
    end

    assign halted      = (run_state == ST_HALT);
    assign instr_ready = (run_state == ST_RUN);
`else
    assign halted      = 1'b0;
    assign instr_ready = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Register file: cleared on reset, written by ADD (dest = lo field)
    // and LOAD (dest = rt field).
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (fire) begin
            if (f_op == OP_ADD) begin
                regs[f_lo] <= sum;
            end else if (f_op == OP_LOAD) begin
                regs[f_rt] <= load_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data memory: reset loads a known pattern (lower half counts up from 0,
    // upper half counts down from 0 as two's complement); STORE writes rt.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= (i < MEM_DEPTH / 2) ? DATA_W'(i)
                                              : DATA_W'(MEM_DEPTH / 2 - i);
            end
        end else if (fire && (f_op == OP_STORE)) begin
            mem[mem_addr] <= op_b;
        end
    end

    // ------------------------------------------------------------------
    // PC, trace outputs, strobes and sticky overflow. Strobes are cleared
    // every cycle and raised only for the instruction just executed.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pc        <= '0;
            op        <= OP_ADD;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            reg_write <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            ovf       <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            reg_write <= 1'b0;
            if (fire) begin
                op <= f_op;
                pc <= (f_op == OP_JUMP) ? pc_jump : pc_seq;
                case (f_op)
                    OP_ADD: begin
                        reg_write <= 1'b1;
                        wb_reg    <= f_lo;
                        wb_data   <= sum;
                        if (add_ovf) begin
                            ovf <= 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        mem_read  <= 1'b1;
                        reg_write <= 1'b1;
                        wb_reg    <= f_rt;
                        wb_data   <= load_data;
                    end
                    OP_STORE: begin
                        mem_write <= 1'b1;
                    end
                    default: begin
                        // JUMP: only the PC changes.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_microprocessor_core.sv
// tb_param_microprocessor_core
//   Directed walk through the core's documented scenarios followed by a
//   randomized instruction stream. Expected values come from a behavioural
//   model of the ISA (integer registers, integer memory, integer PC) kept
//   in this file. Build with CPU_HALT_EN defined to exercise the halt path.
module tb_param_microprocessor_core;

    localparam int DATA_W  = 8;
    localparam int RA_W    = 2;
    localparam int MEM_AW  = 5;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 2 + 3 * RA_W;

    localparam int DMOD  = 2 ** DATA_W;
    localparam int AMOD  = 2 ** MEM_AW;
    localparam int PMOD  = 2 ** PC_W;
    localparam int NREGS = 2 ** RA_W;

    // Clock and DUT signals
    logic                 clock;
    logic                 reset;
    logic [INSTR_W-1:0]   instruction;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [PC_W-1:0]      instruction_address;
    logic [1:0]           op;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic [RA_W-1:0]      wb_reg;
    logic [DATA_W-1:0]    wb_data;
    logic                 ovf;
    logic                 halted;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_regs [NREGS];
    int m_mem  [AMOD];
    int m_pc, m_op, m_rd, m_wr, m_rw, m_wbr, m_wbd, m_ovf, m_halt;

    param_microprocessor_core #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W),
        .MEM_AW (MEM_AW),
        .PC_W   (PC_W)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .instruction         (instruction),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instruction_address (instruction_address),
        .op                  (op),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .reg_write           (reg_write),
        .wb_reg              (wb_reg),
        .wb_data             (wb_data),
        .ovf                 (ovf),
        .halted              (halted)
    );

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int wrap(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    function automatic int to_signed(input int x, input int bits);
        return (x >= 2 ** (bits - 1)) ? x - 2 ** bits : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        for (int i = 0; i < AMOD; i++)
            m_mem[i] = (i < AMOD / 2) ? i : wrap(-(i - AMOD / 2), DMOD);
        m_pc = 0; m_op = 0; m_rd = 0; m_wr = 0; m_rw = 0;
        m_wbr = 0; m_wbd = 0; m_ovf = 0; m_halt = 0;
    endtask

    task automatic model_exec(input int ins);
        int o, rs, rt, lo, imm, joff, addr, s;
        o    = ins / 64;
        rs   = (ins / 16) % 4;
        rt   = (ins / 4) % 4;
        lo   = ins % 4;
        imm  = to_signed(lo, RA_W);
        joff = to_signed(ins % 64, 3 * RA_W);
        addr = wrap(m_regs[rs] + imm, AMOD);
        m_op = o;
        if (o == 3) begin
            m_pc = wrap(m_pc + 1 + joff, PMOD);
`ifdef CPU_HALT_EN
            if (joff == -1) m_halt = 1;
`endif
        end else begin
            m_pc = wrap(m_pc + 1, PMOD);
        end
        case (o)
            0: begin
                s = to_signed(m_regs[rs], DATA_W) + to_signed(m_regs[rt], DATA_W);
                if (s > DMOD / 2 - 1 || s < -(DMOD / 2)) m_ovf = 1;
                m_regs[lo] = wrap(m_regs[rs] + m_regs[rt], DMOD);
                m_rw = 1; m_wbr = lo; m_wbd = m_regs[lo];
            end
            1: begin
                m_regs[rt] = m_mem[addr];
                m_rd = 1; m_rw = 1; m_wbr = rt; m_wbd = m_regs[rt];
            end
            2: begin
                m_mem[addr] = m_regs[rt];
                m_wr = 1;
            end
            default: begin
            end
        endcase
    endtask

    task automatic model_edge(input int ins, input bit v, input bit rst);
        if (rst) begin
            model_reset();
        end else begin
            m_rd = 0; m_wr = 0; m_rw = 0;
            if (v && !m_halt) model_exec(ins);
        end
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},        {24'b0, instruction_address}, m_pc);
        check({tag, ".op"},        {30'b0, op},                  m_op);
        check({tag, ".mem_read"},  {31'b0, mem_read},            m_rd);
        check({tag, ".mem_write"}, {31'b0, mem_write},           m_wr);
        check({tag, ".reg_write"}, {31'b0, reg_write},           m_rw);
        check({tag, ".wb_reg"},    {30'b0, wb_reg},              m_wbr);
        check({tag, ".wb_data"},   {24'b0, wb_data},             m_wbd);
        check({tag, ".ovf"},       {31'b0, ovf},                 m_ovf);
        check({tag, ".halted"},    {31'b0, halted},              m_halt);
        check({tag, ".ready"},     {31'b0, instr_ready},         32'(!m_halt));
    endtask

    // Driver: present one cycle of inputs, let the edge happen, advance the
    // model, then compare 1 time unit after the edge.
    task automatic step(input string tag, input logic [7:0] ins, input bit v, input bit rst);
        instruction = ins;
        instr_valid = v;
        reset       = rst;
        @(posedge clock);
        model_edge(int'(ins), v, rst);
        #1;
        check_all(tag);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] rins;
        bit         rv;
        bit         rr;

        instruction = '0;
        instr_valid = 1'b0;
        reset       = 1'b1;
        model_reset();

        // Reset state
        step("rst0", 8'h00, 1'b0, 1'b1);
        step("rst1", 8'h00, 1'b0, 1'b1);
        check("rst_pc", {24'b0, instruction_address}, 32'h0);
        check("rst_wb_data", {24'b0, wb_data}, 32'h0);

        // LOAD r1 <= M[r0+1]
        step("ld_45", 8'h45, 1'b1, 1'b0);
        check("ld_wb_data", {24'b0, wb_data}, 32'h01);
        check("ld_mem_read", {31'b0, mem_read}, 32'h1);
        check("ld_pc", {24'b0, instruction_address}, 32'h1);

        // ADD r2 = r1 + r1 (dependent, no forwarding needed)
        step("add_16", 8'h16, 1'b1, 1'b0);
        check("add_wb_data", {24'b0, wb_data}, 32'h02);
        check("add_mem_read", {31'b0, mem_read}, 32'h0);

        // Three stall cycles
        step("stall0", 8'h16, 1'b0, 1'b0);
        step("stall1", 8'h16, 1'b0, 1'b0);
        step("stall2", 8'h16, 1'b0, 1'b0);
        check("stall_pc", {24'b0, instruction_address}, 32'h2);
        check("stall_reg_write", {31'b0, reg_write}, 32'h0);

        // STORE r2 -> M[r0-1] = M[31], then LOAD r3 <= M[31]
        step("st_8b", 8'h8B, 1'b1, 1'b0);
        check("st_mem_write", {31'b0, mem_write}, 32'h1);
        step("ld_4f", 8'h4F, 1'b1, 1'b0);
        check("ld31_wb_data", {24'b0, wb_data}, 32'h02);

        // JUMP +2 at PC=4
        step("jmp_c2", 8'hC2, 1'b1, 1'b0);
        check("jmp_pc", {24'b0, instruction_address}, 32'h7);

        // ADD r1 = r1 + r1 seven times: 1 -> 0x80 sets signed overflow
        for (int i = 0; i < 7; i++) step("dbl_15", 8'h15, 1'b1, 1'b0);
        check("dbl_wb_data", {24'b0, wb_data}, 32'h80);
        check("dbl_ovf", {31'b0, ovf}, 32'h1);

        // Non-overflowing ADD leaves ovf sticky
        step("add_00", 8'h00, 1'b1, 1'b0);
        check("ovf_sticky", {31'b0, ovf}, 32'h1);

        // STORE, then reset asserted during its strobe cycle
        step("st2_8b", 8'h8B, 1'b1, 1'b0);
        check("st2_mem_write", {31'b0, mem_write}, 32'h1);
        step("rst_st", 8'h8B, 1'b1, 1'b1);
        check("rst_st_mem_write", {31'b0, mem_write}, 32'h0);
        check("rst_st_pc", {24'b0, instruction_address}, 32'h0);
        check("rst_st_ovf", {31'b0, ovf}, 32'h0);

        // Build r2 = 16 and LOAD r3 <= M[r2+1] = M[17]
        step("m17_45", 8'h45, 1'b1, 1'b0);
        step("m17_16", 8'h16, 1'b1, 1'b0);
        step("m17_2a", 8'h2A, 1'b1, 1'b0);
        step("m17_2a", 8'h2A, 1'b1, 1'b0);
        step("m17_2a", 8'h2A, 1'b1, 1'b0);
        step("m17_6d", 8'h6D, 1'b1, 1'b0);
        check("m17_wb_data", {24'b0, wb_data}, 32'hFF);

        // JUMP +2 from PC=6 to PC=9, then the self-loop
        step("to9_c2", 8'hC2, 1'b1, 1'b0);
        check("to9_pc", {24'b0, instruction_address}, 32'h9);
        step("self_ff", 8'hFF, 1'b1, 1'b0);
        check("self_pc", {24'b0, instruction_address}, 32'h9);
`ifdef CPU_HALT_EN
        check("halt_halted", {31'b0, halted}, 32'h1);
        check("halt_ready", {31'b0, instr_ready}, 32'h0);
        step("frozen0", 8'h45, 1'b1, 1'b0);
        step("frozen1", 8'h45, 1'b1, 1'b0);
        check("frozen_pc", {24'b0, instruction_address}, 32'h9);
        check("frozen_reg_write", {31'b0, reg_write}, 32'h0);
`else
        check("nohalt_halted", {31'b0, halted}, 32'h0);
        check("nohalt_ready", {31'b0, instr_ready}, 32'h1);
        step("self2_ff", 8'hFF, 1'b1, 1'b0);
        check("self2_pc", {24'b0, instruction_address}, 32'h9);
`endif

        // Randomized stream with occasional stalls and resets
        step("rnd_rst", 8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            rins = 8'($urandom_range(0, 255));
            if (rins == 8'hFF) rins = 8'hC0;
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 59) == 0);
            step("rnd", rins, rv, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
